mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand and result width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of any in-flight or held operation.
REQ-005 SHALL have port in_valid  input  1  operands and ALUSel valid this cycle.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operation this cycle.
REQ-007 SHALL have port A  input  N  first operand (rs1).
REQ-008 SHALL have port B  input  N  second operand (rs2).
REQ-009 SHALL have port ALUSel  input  4  op select: 1000 mul, 1001 mulh, 1010 mulhsu, 1011 mulhu.
REQ-010 SHALL have port out_valid  output  1  MulRes holds a completed result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts MulRes this cycle.
REQ-012 SHALL have port MulRes  output  N  selected product half.

Function
REQ-013 SHALL implement three states: IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept an op when in_valid&&in_ready&&!flush: latch |A|, |B|, result sign, ALUSel; clear iteration counter and 2N-bit accumulator; go BUSY.
REQ-016 SHALL treat A as signed for mulh/mulhsu, B as signed for mulh only; mul uses unsigned magnitudes (low half sign-agnostic).
REQ-017 SHALL take magnitude of -2^(N-1) as 2^(N-1) unsigned, without overflow.
REQ-018 SHALL perform one radix-2 shift-add step per BUSY cycle; exactly N BUSY cycles.
REQ-019 SHALL, on the last BUSY cycle, apply two's-complement negation to the 2N-bit product when result sign is negative; go DONE.
REQ-020 SHALL set out_valid in the cycle N+1 after acceptance (acceptance edge = cycle 0).
REQ-021 SHALL output the low N bits for mul, the high N bits for mulh/mulhsu/mulhu.
REQ-022 SHALL produce MulRes=0, same latency, for any ALUSel[3:2]!=2'b10.
REQ-023 SHALL hold MulRes and out_valid stable in DONE while out_ready=0.
REQ-024 SHALL return to IDLE on the edge where out_valid&&out_ready; in_ready rises the next cycle (no same-cycle back-to-back).
REQ-025 SHALL, on flush in any state, go IDLE at the next edge, discard the result, clear out_valid; flush wins over simultaneous in_valid or out_ready.
REQ-026 SHALL ignore A, B, ALUSel changes outside the acceptance cycle.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state IDLE, counter 0, accumulator 0, MulRes 0, out_valid 0, in_ready 1.
REQ-028 SHALL abandon any in-flight operation on reset with no output ever produced for it.
REQ-029 SHALL accept a new op on the first rising clk edge after rst_n deasserts.

Structure
REQ-030 SHALL take ALUSel encodings (incl. the four M-extension codes) and state encodings from the shared core package, used by ALU, decoder and this unit alike.
REQ-031 SHALL be a single module with no sub-modules; the datapath is one N-bit adder plus shift registers.

Verification
REQ-032 SHALL check mul A=7, B=0xFFFFFFFD -> MulRes 0xFFFFFFEB, out_valid exactly at cycle 33.
REQ-033 SHALL check mulh A=B=0x80000000 -> 0x40000000; mul same operands -> 0x00000000.
REQ-034 SHALL check mulhsu A=B=0xFFFFFFFF -> 0xFFFFFFFF; mulhu same -> 0xFFFFFFFE.
REQ-035 SHALL check backpressure: out_ready=0 for 5 cycles in DONE -> MulRes/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 SHALL check flush at cycle 10 of BUSY, and rst_n pulsed low mid-BUSY -> no out_valid, in_ready=1 afterward, next op (mulhu 3*5 -> 0) correct.
REQ-037 SHALL check ALUSel=0000 with A=5, B=6 -> MulRes 0 at cycle 33.

Source files
------------

// File: rtl/mul_unit_pkg.sv
// Shared core encodings: ALUSel op codes and the multiplier's FSM state codes.
// ALU, decoder and mul_unit all import this package.
package mul_unit_pkg;

   localparam logic [3:0] AluAdd    = 4'b0000;
   localparam logic [3:0] AluSub    = 4'b0001;
   localparam logic [3:0] AluAnd    = 4'b0010;
   localparam logic [3:0] AluOr     = 4'b0011;
   localparam logic [3:0] AluXor    = 4'b0100;
   localparam logic [3:0] AluSll    = 4'b0101;
   localparam logic [3:0] AluSrl    = 4'b0110;
   localparam logic [3:0] AluSra    = 4'b0111;
   localparam logic [3:0] AluMul    = 4'b1000;
   localparam logic [3:0] AluMulh   = 4'b1001;
   localparam logic [3:0] AluMulhsu = 4'b1010;
   localparam logic [3:0] AluMulhu  = 4'b1011;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   function automatic logic is_mul_op(input logic [3:0] sel);
      return sel[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for the M-extension mul/mulh/mulhsu/mulhu ops.
// Sign-magnitude: multiply magnitudes over N cycles, then negate the 2N-bit product if needed.
module mul_unit
   import mul_unit_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [3:0]   ALUSel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] MulRes
);

   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);
   localparam logic [N-1:0] OneN = N'(1);
   localparam logic [2*N-1:0] One2N = (2 * N)'(1);

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2*N-1:0]  acc_q, acc_d;
   logic [N-1:0]    mcand_q, mcand_d, mplier_q, mplier_d, res_q, res_d;
   logic [3:0]      sel_q, sel_d;
   logic            neg_q, neg_d;

   logic            a_neg, b_neg;
   logic [N-1:0]    a_mag, b_mag;
   logic [N:0]      sum;
   logic [2*N-1:0]  step, prod;

   // -2^(N-1) negates to itself, which is the correct unsigned magnitude.
   assign a_neg = A[N-1] & ((ALUSel == AluMulh) || (ALUSel == AluMulhsu));
   assign b_neg = B[N-1] & (ALUSel == AluMulh);
   assign a_mag = a_neg ? (~A + OneN) : A;
   assign b_mag = b_neg ? (~B + OneN) : B;

   assign sum  = {1'b0, acc_q[2*N-1:N]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
   assign step = {sum, acc_q[N-1:1]};
   assign prod = neg_q ? (~step + One2N) : step;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      res_d    = res_q;
      sel_d    = sel_q;
      neg_d    = neg_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               neg_d    = a_neg ^ b_neg;
               sel_d    = ALUSel;
               cnt_d    = '0;
               acc_d    = '0;
               state_d  = StBusy;
            end
         end
         StBusy: begin
            acc_d    = step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntOne;
            if (cnt_q == CntLast) begin
               acc_d   = prod;
               state_d = StDone;
               if (sel_q == AluMul) begin
                  res_d = prod[N-1:0];
               end else if (is_mul_op(sel_q)) begin
                  res_d = prod[2*N-1:N];
               end else begin
                  res_d = '0;
               end
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
         acc_d   = '0;
         res_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         res_q    <= '0;
         sel_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         res_q    <= res_d;
         sel_q    <= sel_d;
         neg_q    <= neg_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign MulRes    = res_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus random ops against a
// 64-bit arithmetic reference model.
module tb_mul_unit;

   localparam int unsigned N = 32;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [N-1:0]  A, B, MulRes;
   logic [3:0]    ALUSel;
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   mul_unit #(.N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .ALUSel   (ALUSel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .MulRes   (MulRes)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: full 64-bit products from sign/zero-extended operands.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sel);
      logic [63:0] as_, bs, au, bu, p;
      as_ = {{32{a[31]}}, a};
      bs  = {{32{b[31]}}, b};
      au  = {32'b0, a};
      bu  = {32'b0, b};
      case (sel)
         4'b1000: begin p = au * bu;  return p[31:0];  end
         4'b1001: begin p = as_ * bs; return p[63:32]; end
         4'b1010: begin p = as_ * bu; return p[63:32]; end
         4'b1011: begin p = au * bu;  return p[63:32]; end
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h0;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Present an op at a negedge while in_ready; returns at the negedge after the accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_eq("in_ready_before_issue", {63'b0, in_ready}, 64'd1);
      A = a;
      B = b;
      ALUSel = sel;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
      ALUSel = 4'($urandom);
   endtask

   // Called at the negedge of cycle 1; expects out_valid first in cycle N+1.
   task automatic finish_op(input string tag, input logic [31:0] exp, input int hold);
      int lat = 1;
      logic [31:0] r0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check_eq({tag, "_latency"}, 64'(lat), 64'(N + 1));
      check_eq({tag, "_result"}, {32'b0, MulRes}, {32'b0, exp});
      check_eq({tag, "_in_ready_done"}, {63'b0, in_ready}, 64'd0);
      r0 = MulRes;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq({tag, "_hold_valid"}, {63'b0, out_valid}, 64'd1);
         check_eq({tag, "_hold_res"}, {32'b0, MulRes}, {32'b0, r0});
         check_eq({tag, "_hold_in_ready"}, {63'b0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_valid_after_take"}, {63'b0, out_valid}, 64'd0);
      check_eq({tag, "_in_ready_after_take"}, {63'b0, in_ready}, 64'd1);
   endtask

   task automatic watch_no_valid(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_eq(tag, 64'(seen), 64'd0);
      check_eq({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
   endtask

   initial begin
      logic [31:0] a, b;
      logic [3:0]  sel;
      int          r;
      rst_n = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      A = '0;
      B = '0;
      ALUSel = '0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("reset_in_ready", {63'b0, in_ready}, 64'd1);
      check_eq("reset_out_valid", {63'b0, out_valid}, 64'd0);
      check_eq("reset_mulres", {32'b0, MulRes}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      issue(32'd7, 32'hFFFF_FFFD, 4'b1000);
      finish_op("mul_7_neg3", 32'hFFFF_FFEB, 0);
      issue(32'h8000_0000, 32'h8000_0000, 4'b1001);
      finish_op("mulh_min_min", 32'h4000_0000, 0);
      issue(32'h8000_0000, 32'h8000_0000, 4'b1000);
      finish_op("mul_min_min", 32'h0, 0);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010);
      finish_op("mulhsu_ones", 32'hFFFF_FFFF, 0);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1011);
      finish_op("mulhu_ones", 32'hFFFF_FFFE, 0);

      // Reset mid-BUSY: outputs clear asynchronously and the op never completes.
      issue(32'h1234_5678, 32'h9ABC_DEF0, 4'b1011);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midreset_in_ready", {63'b0, in_ready}, 64'd1);
      check_eq("midreset_out_valid", {63'b0, out_valid}, 64'd0);
      check_eq("midreset_mulres", {32'b0, MulRes}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_valid("midreset_no_valid", 40);

      // Accept on the very first edge after reset release.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      A = 32'd3;
      B = 32'd5;
      ALUSel = 4'b1011;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("accept_first_edge", {63'b0, in_ready}, 64'd0);
      finish_op("mulhu_3_5_after_reset", 32'h0, 0);

      // Flush at BUSY cycle 10.
      issue(32'hDEAD_BEEF, 32'h1357_9BDF, 4'b1001);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      watch_no_valid("flush_no_valid", 40);
      issue(32'd3, 32'd5, 4'b1011);
      finish_op("mulhu_3_5_after_flush", 32'h0, 0);

      // Flush beats a simultaneous in_valid in IDLE.
      @(negedge clk);
      A = 32'd9;
      B = 32'd9;
      ALUSel = 4'b1000;
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;
      check_eq("flush_beats_in_valid", {63'b0, in_ready}, 64'd1);

      issue(32'd5, 32'd6, 4'b0000);
      finish_op("bad_sel_0000", 32'h0, 0);
      issue(32'hFFFF_FFF0, 32'd12345, 4'b1001);
      finish_op("backpressure_5", ref_mul(32'hFFFF_FFF0, 32'd12345, 4'b1001), 5);

      for (int k = 0; k < 40; k++) begin
         a = pick_operand();
         b = pick_operand();
         r = $urandom_range(0, 9);
         sel = (r < 8) ? {2'b10, 2'(r)} : 4'($urandom);
         issue(a, b, sel);
         finish_op($sformatf("rand%0d_sel%b", k, sel), ref_mul(a, b, sel),
                   $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
